fwd_hazard_ctrl: RTL and testbench
==================================

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have parameter AW, default 4, register-address width.
REQ-002 SHALL have parameter NSRC, default 2, number of source operands per instruction.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, address 0 never matches a producer.
REQ-004 SHALL have port clk  input  1  single clock; all state on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port id_src  input  NSRC*AW  ID-stage source addresses; operand i is bits [i*AW +: AW].
REQ-007 SHALL have port id_use  input  NSRC  per-operand "source is read" flag.
REQ-008 SHALL have port ex_rd, mem_rd, wb_rd  input  AW each  destination of the instruction in EX, MEM, WB.
REQ-009 SHALL have port ex_wr, mem_wr, wb_wr  input  1 each  that stage writes a register.
REQ-010 SHALL have port ex_load  input  1  the instruction in EX is a load.
REQ-011 SHALL have port pipe_hold  input  1  global freeze, e.g. memory wait.
REQ-012 SHALL have port fwd_sel  output  NSRC*2  registered per-operand bypass select for the EX stage.
REQ-013 SHALL have port stall  output  1  hold PC and IF/ID this cycle.
REQ-014 SHALL have port ex_bubble  output  1  load a NOP into ID/EX on the next edge.

Function
REQ-015 SHALL encode selects as FWD_NONE=00 (register file), FWD_D1=01 (EX/MEM result), FWD_D2=10 (MEM/WB result), FWD_D3=11 (WB write data).
REQ-016 SHALL compute per operand: a match when id_use[i], stage wr is 1, stage rd equals id_src[i], and not (ZERO_REG and rd==0).
REQ-017 SHALL use nearest-producer priority: ex match gives D1, else mem match gives D2, else wb match gives D3, else NONE; all NSRC operands are resolved independently.
REQ-018 SHALL detect load-use when ex_wr and ex_load are set and any operand matches ex_rd.
REQ-019 SHALL run FSM states RUN and STALL; RUN goes to STALL on load-use with pipe_hold low; STALL returns to RUN after exactly one cycle with pipe_hold low.
REQ-020 SHALL drive stall and ex_bubble combinationally high in RUN when load-use is detected; in STALL both are low.
REQ-021 SHALL register fwd_sel on each edge with pipe_hold low: all NONE if load-use is detected this cycle, otherwise the resolved selects; latency is one cycle, ID to EX.
REQ-022 SHALL in the cycle after a stall, with the load now in MEM and a bubble in EX, resolve the dependent operand to D2.
REQ-023 SHALL, while pipe_hold is high, hold FSM state and fwd_sel, and force stall and ex_bubble low.
REQ-024 SHALL give simultaneous matching producers the nearest one; a load-use match overrides any D2 or D3 match on the other operand.

Reset
REQ-025 SHALL, on rst_n low at any time including mid-stall, put the FSM in RUN and fwd_sel to all FWD_NONE immediately; stall and ex_bubble follow from the inputs.
REQ-026 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with macro FWD_HAZARD_PERF_EN defined, add outputs stall_cnt[31:0] and fwd_cnt[31:0].
REQ-028 SHALL, under FWD_HAZARD_PERF_EN, increment stall_cnt on each edge where stall is high and fwd_cnt on each edge where a non-NONE fwd_sel is loaded; both saturate at all-ones and reset to 0.
REQ-029 SHALL, without the macro, have neither those ports nor any counter logic.

Structure
REQ-030 SHALL place the FWD_NONE/D1/D2/D3 constants, the 2-bit fwd_sel_t typedef, and the FSM state typedef in shared package pipe_pkg.
REQ-031 SHALL implement per-operand match and priority in sub-module fwd_resolve (one instance per operand, generate loop); the FSM, registers and counters stay in the top.

Verification
REQ-032 SHALL cover: src0=3 used, ex_rd=3 ex_wr=1 ex_load=0 -> next-cycle fwd_sel[1:0]=01, stall=0.
REQ-033 SHALL cover: src0=5, ex_rd=5 and mem_rd=5, both wr=1 -> fwd_sel[1:0]=01 (nearest wins, not 10).
REQ-034 SHALL cover: ex_load=1 ex_rd=7, src1=7 -> stall=1 and ex_bubble=1 for exactly one cycle, fwd_sel all 00; next cycle mem_rd=7 -> fwd_sel[3:2]=10.
REQ-035 SHALL cover: src0=0, wb_rd=0 wb_wr=1, ZERO_REG=1 -> fwd_sel[1:0]=00; with ZERO_REG=0 -> 11.
REQ-036 SHALL cover: load-use with pipe_hold=1 held for 3 cycles -> stall=0 and fwd_sel frozen; after release, one stall cycle.
REQ-037 SHALL cover: rst_n pulsed low in STALL -> fwd_sel=00 at once, RUN after release; with FWD_HAZARD_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the forwarding / hazard controller.
//   fwd_sel_t  : 2-bit bypass select for one EX-stage operand
//   FWD_*      : select encodings (register file, EX/MEM, MEM/WB, WB write data)
//   hz_state_e : hazard FSM state
package pipe_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE = 2'b00;
  localparam fwd_sel_t FWD_D1   = 2'b01;
  localparam fwd_sel_t FWD_D2   = 2'b10;
  localparam fwd_sel_t FWD_D3   = 2'b11;

  typedef enum logic {
    StRun,
    StStall
  } hz_state_e;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Pipeline-side bundle for fwd_hazard_ctrl.
//   master : the pipeline; drives ID sources, producer info and pipe_hold,
//            receives fwd_sel / stall / ex_bubble
//   slave  : the controller
interface fwd_hazard_ctrl_if #(
  parameter int unsigned AW   = 4,
  parameter int unsigned NSRC = 2
);
  logic [NSRC*AW-1:0] id_src;
  logic [NSRC-1:0]    id_use;
  logic [AW-1:0]      ex_rd;
  logic [AW-1:0]      mem_rd;
  logic [AW-1:0]      wb_rd;
  logic               ex_wr;
  logic               mem_wr;
  logic               wb_wr;
  logic               ex_load;
  logic               pipe_hold;
  logic [NSRC*2-1:0]  fwd_sel;
  logic               stall;
  logic               ex_bubble;

  modport master (
    output id_src, id_use, ex_rd, mem_rd, wb_rd, ex_wr, mem_wr, wb_wr, ex_load, pipe_hold,
    input  fwd_sel, stall, ex_bubble
  );

  modport slave (
    input  id_src, id_use, ex_rd, mem_rd, wb_rd, ex_wr, mem_wr, wb_wr, ex_load, pipe_hold,
    output fwd_sel, stall, ex_bubble
  );
endinterface

// File: rtl/fwd_resolve.sv
// Per-operand producer match and nearest-producer priority.
//   src_i/use_i        : ID-stage source address and its read flag
//   {ex,mem,wb}_rd_i/wr_i : destination and write-enable of each producer stage
//   sel_o              : resolved bypass select
//   ex_hit_o           : operand depends on the instruction in EX
module fwd_resolve
  import pipe_pkg::*;
#(
  parameter int unsigned AW       = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic [AW-1:0] src_i,
  input  logic          use_i,
  input  logic [AW-1:0] ex_rd_i,
  input  logic          ex_wr_i,
  input  logic [AW-1:0] mem_rd_i,
  input  logic          mem_wr_i,
  input  logic [AW-1:0] wb_rd_i,
  input  logic          wb_wr_i,
  output fwd_sel_t      sel_o,
  output logic          ex_hit_o
);

  logic ex_hit, mem_hit, wb_hit;

  // Hardwired zero register is never a real producer.
  assign ex_hit  = use_i && ex_wr_i  && (ex_rd_i  == src_i) && !(ZERO_REG != 0 && ex_rd_i  == '0);
  assign mem_hit = use_i && mem_wr_i && (mem_rd_i == src_i) && !(ZERO_REG != 0 && mem_rd_i == '0);
  assign wb_hit  = use_i && wb_wr_i  && (wb_rd_i  == src_i) && !(ZERO_REG != 0 && wb_rd_i  == '0);

  always_comb begin
    sel_o = FWD_NONE;
    if (ex_hit)       sel_o = FWD_D1;
    else if (mem_hit) sel_o = FWD_D2;
    else if (wb_hit)  sel_o = FWD_D3;
  end

  assign ex_hit_o = ex_hit;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fwd_hazard_ctrl_if.slave (ID sources, producers, pipe_hold in;
//                registered fwd_sel, combinational stall / ex_bubble out)
//   stall_cnt, fwd_cnt : saturating performance counters, present only when
//                FWD_HAZARD_PERF_EN is defined
module fwd_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned AW       = 4,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  fwd_hazard_ctrl_if.slave    bus
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         fwd_cnt
`endif
);

  fwd_sel_t          res_sel [NSRC];
  logic [NSRC-1:0]   ex_hit;
  logic              load_use;
  logic [NSRC*2-1:0] fwd_d, fwd_q;
  hz_state_e         state_q;

  for (genvar i = 0; i < NSRC; i++) begin : g_res
    fwd_resolve #(
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_res (
      .src_i    (bus.id_src[i*AW +: AW]),
      .use_i    (bus.id_use[i]),
      .ex_rd_i  (bus.ex_rd),
      .ex_wr_i  (bus.ex_wr),
      .mem_rd_i (bus.mem_rd),
      .mem_wr_i (bus.mem_wr),
      .wb_rd_i  (bus.wb_rd),
      .wb_wr_i  (bus.wb_wr),
      .sel_o    (res_sel[i]),
      .ex_hit_o (ex_hit[i])
    );
  end

  // ex_hit already requires ex_wr, so a load-use is a load with any EX dependency.
  assign load_use = bus.ex_load && (|ex_hit);

  // A load-use inserts a bubble into EX, so nothing gets bypassed there.
  always_comb begin
    fwd_d = '0;
    for (int i = 0; i < NSRC; i++) begin
      fwd_d[2*i +: 2] = load_use ? FWD_NONE : res_sel[i];
    end
  end

  assign bus.stall     = (state_q == StRun) && load_use && !bus.pipe_hold;
  assign bus.ex_bubble = bus.stall;
  assign bus.fwd_sel   = fwd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      fwd_q   <= '0;
    end else if (!bus.pipe_hold) begin
      fwd_q <= fwd_d;
      unique case (state_q)
        StRun:   if (load_use) state_q <= StStall;
        StStall: state_q <= StRun;
        default: state_q <= StRun;
      endcase
    end
  end

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (bus.stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (!bus.pipe_hold && (|fwd_d) && fwd_cnt_q != '1) fwd_cnt_q <= fwd_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: two instances (ZERO_REG=1 and ZERO_REG=0) share
// stimulus; a rule-level model is compared on every falling edge, and directed
// steps carry hand-computed literal expectations.
module tb_fwd_hazard_ctrl;

  logic clk;
  logic rst_n;

  logic [7:0] s_src;
  logic [1:0] s_use;
  logic [3:0] s_exrd, s_memrd, s_wbrd;
  logic       s_exwr, s_memwr, s_wbwr, s_ld, s_hold;

  int checks = 0;
  int errors = 0;

  fwd_hazard_ctrl_if #(.AW(4), .NSRC(2)) bus ();
  fwd_hazard_ctrl_if #(.AW(4), .NSRC(2)) bus_z0 ();

  assign bus.id_src    = s_src;
  assign bus.id_use    = s_use;
  assign bus.ex_rd     = s_exrd;
  assign bus.mem_rd    = s_memrd;
  assign bus.wb_rd     = s_wbrd;
  assign bus.ex_wr     = s_exwr;
  assign bus.mem_wr    = s_memwr;
  assign bus.wb_wr     = s_wbwr;
  assign bus.ex_load   = s_ld;
  assign bus.pipe_hold = s_hold;

  assign bus_z0.id_src    = s_src;
  assign bus_z0.id_use    = s_use;
  assign bus_z0.ex_rd     = s_exrd;
  assign bus_z0.mem_rd    = s_memrd;
  assign bus_z0.wb_rd     = s_wbrd;
  assign bus_z0.ex_wr     = s_exwr;
  assign bus_z0.mem_wr    = s_memwr;
  assign bus_z0.wb_wr     = s_wbwr;
  assign bus_z0.ex_load   = s_ld;
  assign bus_z0.pipe_hold = s_hold;

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] sc, fc, sc_z0, fc_z0;
`endif

  fwd_hazard_ctrl #(.AW(4), .NSRC(2), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FWD_HAZARD_PERF_EN
    ,
    .stall_cnt (sc),
    .fwd_cnt   (fc)
`endif
  );

  fwd_hazard_ctrl #(.AW(4), .NSRC(2), .ZERO_REG(0)) dut_z0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_z0)
`ifdef FWD_HAZARD_PERF_EN
    ,
    .stall_cnt (sc_z0),
    .fwd_cnt   (fc_z0)
`endif
  );

  logic [7:0] g_fwd;
  logic [1:0] g_stall, g_bub;
  assign g_fwd   = {bus_z0.fwd_sel, bus.fwd_sel};
  assign g_stall = {bus_z0.stall, bus.stall};
  assign g_bub   = {bus_z0.ex_bubble, bus.ex_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Nearest producer wins: scan far-to-near so the nearest overwrites.
  function automatic logic [1:0] res(input int zr, input logic [3:0] src, input logic u);
    logic [3:0] rd [3];
    logic       wr [3];
    logic [1:0] r;
    rd[0] = s_exrd;  wr[0] = s_exwr;
    rd[1] = s_memrd; wr[1] = s_memwr;
    rd[2] = s_wbrd;  wr[2] = s_wbwr;
    r = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (u && wr[k] && rd[k] == src && !(zr != 0 && rd[k] == 4'd0)) r = 2'(k + 1);
    end
    return r;
  endfunction

  function automatic logic lu(input int zr);
    return s_ld && (res(zr, s_src[3:0], s_use[0]) == 2'd1 ||
                    res(zr, s_src[7:4], s_use[1]) == 2'd1);
  endfunction

  // Index 0 models ZERO_REG=1, index 1 models ZERO_REG=0.
  logic [7:0] m_fwd = '0;
  logic [1:0] m_stl = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fwd <= '0;
      m_stl <= '0;
    end else if (!s_hold) begin
      for (int z = 0; z < 2; z++) begin
        m_stl[z] <= m_stl[z] ? 1'b0 : lu(1 - z);
        m_fwd[z*4 +: 4] <= lu(1 - z) ? 4'b0000 :
                           {res(1 - z, s_src[7:4], s_use[1]), res(1 - z, s_src[3:0], s_use[0])};
      end
    end
  end

  always @(negedge clk) begin
    for (int z = 0; z < 2; z++) begin
      logic exp_st;
      exp_st = !s_hold && !m_stl[z] && lu(1 - z);
      chk($sformatf("model_fwd%0d", z), 32'(g_fwd[z*4 +: 4]), 32'(m_fwd[z*4 +: 4]));
      chk($sformatf("model_stall%0d", z), 32'(g_stall[z]), 32'(exp_st));
      chk($sformatf("model_bubble%0d", z), 32'(g_bub[z]), 32'(exp_st));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic [3:0] src0, input logic [3:0] src1, input logic [1:0] u,
                       input logic [3:0] exrd, input logic exwr, input logic ld,
                       input logic [3:0] memrd, input logic memwr,
                       input logic [3:0] wbrd, input logic wbwr, input logic hold);
    s_src = {src1, src0}; s_use = u;
    s_exrd = exrd; s_exwr = exwr; s_ld = ld;
    s_memrd = memrd; s_memwr = memwr;
    s_wbrd = wbrd; s_wbwr = wbwr; s_hold = hold;
  endtask

  initial begin
    rst_n = 1'b0;
    setin(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_fwd", 32'(bus.fwd_sel), 32'h0);
    chk("reset_stall", 32'(bus.stall), 32'h0);
`ifdef FWD_HAZARD_PERF_EN
    chk("reset_stall_cnt", sc, 32'h0);
    chk("reset_fwd_cnt", fc, 32'h0);
`endif
    tick();
    rst_n = 1'b1;

    // EX producer, not a load
    setin(3, 0, 2'b01, 3, 1, 0, 0, 0, 0, 0, 0);
    #1 chk("ex_fwd_stall", 32'(bus.stall), 32'h0);
    tick();
    chk("ex_fwd_sel", 32'(bus.fwd_sel), 32'h1);

    // EX and MEM both write the source: nearest wins
    setin(5, 0, 2'b01, 5, 1, 0, 5, 1, 0, 0, 0);
    tick();
    chk("nearest_sel", 32'(bus.fwd_sel), 32'h1);

    // Independent operands: op0 from MEM, op1 from WB
    setin(4, 6, 2'b11, 0, 0, 0, 4, 1, 6, 1, 0);
    tick();
    chk("two_op_sel", 32'(bus.fwd_sel), 32'he);

    // Load-use on op1 while op0 has a MEM match: everything NONE
    setin(2, 7, 2'b11, 7, 1, 1, 2, 1, 0, 0, 0);
    #1;
    chk("lu_stall", 32'(bus.stall), 32'h1);
    chk("lu_bubble", 32'(bus.ex_bubble), 32'h1);
    tick();
    chk("lu_fwd_none", 32'(bus.fwd_sel), 32'h0);
    // Load now in MEM, bubble in EX
    setin(0, 7, 2'b10, 0, 0, 0, 7, 1, 0, 0, 0);
    #1;
    chk("lu_stall_once", 32'(bus.stall), 32'h0);
    chk("lu_bubble_once", 32'(bus.ex_bubble), 32'h0);
    tick();
    chk("lu_after_d2", 32'(bus.fwd_sel), 32'h8);

    // Zero register vs ZERO_REG=0
    setin(0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    chk("zero_reg1", 32'(bus.fwd_sel), 32'h0);
    chk("zero_reg0", 32'(bus_z0.fwd_sel), 32'h3);

    // Freeze with a load-use pending
    setin(4, 0, 2'b01, 0, 0, 0, 4, 1, 0, 0, 0);
    tick();
    chk("pre_hold_sel", 32'(bus.fwd_sel), 32'h2);
    setin(9, 0, 2'b01, 9, 1, 1, 0, 0, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_stall", 32'(bus.stall), 32'h0);
      chk("hold_bubble", 32'(bus.ex_bubble), 32'h0);
      tick();
      chk("hold_frozen", 32'(bus.fwd_sel), 32'h2);
    end
    s_hold = 1'b0;
    #1 chk("release_stall", 32'(bus.stall), 32'h1);
    tick();
    chk("release_fwd", 32'(bus.fwd_sel), 32'h0);
    setin(9, 0, 2'b01, 0, 0, 0, 9, 1, 0, 0, 0);
    #1 chk("release_one_stall", 32'(bus.stall), 32'h0);
    tick();
    chk("release_d2", 32'(bus.fwd_sel), 32'h2);

    // Reset while in STALL
    setin(0, 8, 2'b10, 8, 1, 1, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_stall_fwd", 32'(bus.fwd_sel), 32'h0);
    chk("rst_in_run", 32'(bus.stall), 32'h1);
`ifdef FWD_HAZARD_PERF_EN
    chk("rst_stall_cnt", sc, 32'h0);
    chk("rst_fwd_cnt", fc, 32'h0);
`endif
    tick();
    rst_n = 1'b1;
    #1 chk("post_rst_run", 32'(bus.stall), 32'h1);
    tick();
    setin(3, 0, 2'b01, 3, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("pre_rst_sel", 32'(bus.fwd_sel), 32'h1);
    rst_n = 1'b0;
    #1 chk("rst_async_fwd", 32'(bus.fwd_sel), 32'h0);
    tick();
    rst_n = 1'b1;

    // Mixed traffic on a small register range against the model
    for (int n = 0; n < 80; n++) begin
      setin(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0));
      tick();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
